// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit bus receiver.
// Command codes are matched as (byte & MASK) == CODE, checked in priority order.
package lcd_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        S_8BIT = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } lcd_state_e;

    typedef struct packed {
        logic             rs;
        logic [NIB_W-1:0] nibble;
    } lcd_nib_t;

    localparam logic [NIB_W-1:0] NIB_WAKE  = 4'h3;
    localparam logic [NIB_W-1:0] NIB_FUNC4 = 4'h2;

    localparam logic [BYTE_W-1:0] CMD_CLEAR        = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_CLEAR_MASK   = 8'hFF;
    localparam logic [BYTE_W-1:0] CMD_HOME         = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_HOME_MASK    = 8'hFE;
    localparam logic [BYTE_W-1:0] CMD_ENTRY        = 8'h04;
    localparam logic [BYTE_W-1:0] CMD_ENTRY_MASK   = 8'hFC;
    localparam logic [BYTE_W-1:0] CMD_DISPLAY      = 8'h08;
    localparam logic [BYTE_W-1:0] CMD_DISPLAY_MASK = 8'hF8;
    localparam logic [BYTE_W-1:0] CMD_DDRAM        = 8'h80;
    localparam logic [BYTE_W-1:0] CMD_DDRAM_MASK   = 8'h80;

    function automatic logic cmd_match(input logic [BYTE_W-1:0] b,
                                       input logic [BYTE_W-1:0] code,
                                       input logic [BYTE_W-1:0] mask);
        return (b & mask) == code;
    endfunction

endpackage

// File: rtl/lcd_bus_if.sv
// HD44780 parallel bus as driven by the host MCU (4-bit mode uses db4-db7 only).
interface lcd_bus_if;
    logic db4;
    logic db5;
    logic db6;
    logic db7;
    logic rs;
    logic enable;

    modport master (output db4, db5, db6, db7, rs, enable);
    modport slave  (input  db4, db5, db6, db7, rs, enable);
endinterface

// File: rtl/lcd_strobe_detect.sv
// Synchronizes the asynchronous LCD bus, rejects short enable pulses and
// emits a one-cycle strobe with the nibble/rs captured while enable was high.
module lcd_strobe_detect
    import lcd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned MIN_PULSE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             rs,
    input  logic [NIB_W-1:0] nibble,
    output logic             strobe,
    output lcd_nib_t         strobe_nib
);

    localparam int unsigned SYNC_W = 2 + NIB_W;
    localparam int unsigned CNT_W  = $clog2(MIN_PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_PULSE_CYCLES);

    logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
    logic              en_s;
    logic              en_d;
    logic              fall_c;
    logic [CNT_W-1:0]  cnt;
    lcd_nib_t          hold;
    lcd_nib_t          cur_s;

    // Enable, rs and data share one chain so they stay cycle-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {enable, rs, nibble};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign en_s   = sync_q[SYNC_STAGES-1][SYNC_W-1];
    assign cur_s  = lcd_nib_t'(sync_q[SYNC_STAGES-1][SYNC_W-2:0]);
    assign fall_c = en_d & ~en_s;

    // cnt still holds the pulse length in the cycle enable drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_d       <= 1'b0;
            cnt        <= '0;
            hold       <= '0;
            strobe     <= 1'b0;
            strobe_nib <= '0;
        end else begin
            en_d   <= en_s;
            strobe <= fall_c && (cnt == CNT_MAX);
            if (en_s) begin
                hold <= cur_s;
                if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
            if (fall_c) strobe_nib <= hold;
        end
    end

endmodule

// File: rtl/lcd_bus_receiver.sv
// HD44780-compatible bus receiver: 8-bit wake-up, 4-bit nibble pairing,
// and a minimal command/data decoder tracking the DDRAM cursor.
module lcd_bus_receiver
    import lcd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned MIN_PULSE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    lcd_bus_if.slave          bus,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_rs,
    output logic              byte_valid,
    output logic              char_wr,
    output logic [BYTE_W-1:0] char_data,
    output logic [ADDR_W-1:0] char_addr,
    output logic [ADDR_W-1:0] cursor_addr,
    output logic              clear_seen,
    output logic              home_seen,
    output logic              display_on,
    output logic              mode_4bit,
    output logic              protocol_err
);

    logic              strobe;
    lcd_nib_t          snib;
    lcd_state_e        state;
    logic [1:0]        wake_cnt;
    logic [NIB_W-1:0]  hi_nib;
    logic              hi_rs;
    logic              incr;
    logic [BYTE_W-1:0] byte_c;

    lcd_strobe_detect #(
        .SYNC_STAGES      (SYNC_STAGES),
        .MIN_PULSE_CYCLES (MIN_PULSE_CYCLES)
    ) u_strobe (
        .clk        (clk),
        .rst        (rst),
        .enable     (bus.enable),
        .rs         (bus.rs),
        .nibble     ({bus.db7, bus.db6, bus.db5, bus.db4}),
        .strobe     (strobe),
        .strobe_nib (snib)
    );

    assign byte_c = {hi_nib, snib.nibble};

    // Protocol FSM plus command/data decode, all applied on the strobe cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_8BIT;
            wake_cnt     <= '0;
            hi_nib       <= '0;
            hi_rs        <= 1'b0;
            incr         <= 1'b1;
            byte_out     <= '0;
            byte_rs      <= 1'b0;
            byte_valid   <= 1'b0;
            char_wr      <= 1'b0;
            char_data    <= '0;
            char_addr    <= '0;
            cursor_addr  <= '0;
            clear_seen   <= 1'b0;
            home_seen    <= 1'b0;
            display_on   <= 1'b0;
            mode_4bit    <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            byte_valid   <= 1'b0;
            char_wr      <= 1'b0;
            clear_seen   <= 1'b0;
            home_seen    <= 1'b0;
            protocol_err <= 1'b0;
            if (strobe) begin
                case (state)
                    S_8BIT: begin
                        if (snib.nibble == NIB_WAKE) begin
                            if (wake_cnt != 2'd3) wake_cnt <= wake_cnt + 2'd1;
                        end else if (snib.nibble == NIB_FUNC4 && wake_cnt == 2'd3) begin
                            mode_4bit <= 1'b1;
                            state     <= S_HIGH;
                        end else begin
                            protocol_err <= 1'b1;
                            wake_cnt     <= '0;
                        end
                    end
                    S_HIGH: begin
                        hi_nib <= snib.nibble;
                        hi_rs  <= snib.rs;
                        state  <= S_LOW;
                    end
                    S_LOW: begin
                        state  <= S_HIGH;
                        hi_nib <= '0;
                        if (snib.rs != hi_rs) begin
                            protocol_err <= 1'b1;
                        end else begin
                            byte_out   <= byte_c;
                            byte_rs    <= hi_rs;
                            byte_valid <= 1'b1;
                            if (hi_rs) begin
                                char_wr     <= 1'b1;
                                char_data   <= byte_c;
                                char_addr   <= cursor_addr;
                                cursor_addr <= incr ? cursor_addr + ADDR_W'(1)
                                                    : cursor_addr - ADDR_W'(1);
                            end else if (cmd_match(byte_c, CMD_CLEAR, CMD_CLEAR_MASK)) begin
                                cursor_addr <= '0;
                                incr        <= 1'b1;
                                clear_seen  <= 1'b1;
                            end else if (cmd_match(byte_c, CMD_HOME, CMD_HOME_MASK)) begin
                                cursor_addr <= '0;
                                home_seen   <= 1'b1;
                            end else if (cmd_match(byte_c, CMD_ENTRY, CMD_ENTRY_MASK)) begin
                                incr <= byte_c[1];
                            end else if (cmd_match(byte_c, CMD_DISPLAY, CMD_DISPLAY_MASK)) begin
                                display_on <= byte_c[2];
                            end else if (cmd_match(byte_c, CMD_DDRAM, CMD_DDRAM_MASK)) begin
                                cursor_addr <= byte_c[ADDR_W-1:0];
                            end
                        end
                    end
                    default: state <= S_8BIT;
                endcase
            end
        end
    end

endmodule
